// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes,
// FSM state encoding, divisor floor and the parity helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int DIV_MIN  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Parity over a zero-extended character; unused upper bits do not affect XOR.
    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        logic p_s;
        p_s = 1'b0;
        case (mode)
            PAR_EVEN: p_s = ^d;
            PAR_ODD:  p_s = ~(^d);
            default:  p_s = 1'b0;
        endcase
        return p_s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous show-ahead FIFO; rd_data presents the head entry,
// and full/empty are registered from the post-update occupancy.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             do_wr_s;
    logic             do_rd_s;

    // Qualify requests against current flags; a write while full is never admitted.
    always_comb begin
        do_wr_s     = wr_en && !full_r;
        do_rd_s     = rd_en && !empty_r;
        count_nxt_s = count_r;
        if (do_wr_s && !do_rd_s) begin
            count_nxt_s = count_r + (AW+1)'(1);
        end else if (!do_wr_s && do_rd_s) begin
            count_nxt_s = count_r - (AW+1)'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == (AW+1)'(DEPTH));
            empty_r <= (count_nxt_s == (AW+1)'(0));
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter with runtime baud divisor and compile-time
// data width, parity and stop-bit count.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 12,
    parameter int FIFO_AW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     div,
    input  logic                 we,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 ovf,
    output logic                 busy,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 tx
);

    tx_state_e            state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_r;
    logic [DIV_W-1:0]     baud_r;
    logic [DIV_W-1:0]     div_l_r;
    logic [3:0]           bit_r;
    logic                 tx_r;
    logic                 ovf_r;

    logic [DATA_BITS-1:0] fifo_rd_data_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [FIFO_AW:0]     fifo_count_s;
    logic                 wr_s;
    logic                 pop_s;
    logic                 bit_end_s;
    logic                 last_stop_s;
    logic [DIV_W-1:0]     div_eff_s;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_s),
        .wr_data (data),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Divisor floor, bit-boundary detection and pop decision.
    always_comb begin
        if (div < DIV_W'(DIV_MIN)) begin
            div_eff_s = DIV_W'(DIV_MIN);
        end else begin
            div_eff_s = div;
        end
        wr_s        = we && !fifo_full_s;
        bit_end_s   = (baud_r == div_l_r);
        last_stop_s = (state_r == ST_STOP) && bit_end_s && (bit_r == 4'(STOP_BITS-1));
        pop_s       = !fifo_empty_s && ((state_r == ST_IDLE) || last_stop_s);
    end

    // Frame sequencer: shift register, baud counter and line driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            tx_r    <= 1'b1;
            shift_r <= '0;
            par_r   <= 1'b0;
            baud_r  <= DIV_W'(1);
            div_l_r <= DIV_W'(DIV_MIN);
            bit_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_r <= fifo_rd_data_s;
                        par_r   <= parity_bit(8'(fifo_rd_data_s), PARITY);
                        div_l_r <= div_eff_s;
                        baud_r  <= DIV_W'(1);
                        tx_r    <= 1'b0;
                        state_r <= ST_START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        baud_r  <= DIV_W'(1);
                        tx_r    <= shift_r[0];
                        shift_r <= shift_r >> 1;
                        bit_r   <= 4'd0;
                        state_r <= ST_DATA;
                    end else begin
                        baud_r <= baud_r + DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_r <= DIV_W'(1);
                        if (bit_r == 4'(DATA_BITS-1)) begin
                            bit_r <= 4'd0;
                            if (PARITY != PAR_NONE) begin
                                tx_r    <= par_r;
                                state_r <= ST_PARITY;
                            end else begin
                                tx_r    <= 1'b1;
                                state_r <= ST_STOP;
                            end
                        end else begin
                            tx_r    <= shift_r[0];
                            shift_r <= shift_r >> 1;
                            bit_r   <= bit_r + 4'd1;
                        end
                    end else begin
                        baud_r <= baud_r + DIV_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        baud_r  <= DIV_W'(1);
                        bit_r   <= 4'd0;
                        tx_r    <= 1'b1;
                        state_r <= ST_STOP;
                    end else begin
                        baud_r <= baud_r + DIV_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_r <= DIV_W'(1);
                        if (bit_r == 4'(STOP_BITS-1)) begin
                            // Chain straight into the next start bit when data is waiting.
                            if (pop_s) begin
                                shift_r <= fifo_rd_data_s;
                                par_r   <= parity_bit(8'(fifo_rd_data_s), PARITY);
                                div_l_r <= div_eff_s;
                                tx_r    <= 1'b0;
                                state_r <= ST_START;
                            end else begin
                                tx_r    <= 1'b1;
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            bit_r <= bit_r + 4'd1;
                        end
                    end else begin
                        baud_r <= baud_r + DIV_W'(1);
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Overflow pulse for a write attempted while the FIFO is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= we && fifo_full_s;
        end
    end

    assign ready      = !fifo_full_s;
    assign ovf        = ovf_r;
    assign busy       = (state_r != ST_IDLE) || !fifo_empty_s;
    assign fifo_count = fifo_count_s;
    assign tx         = tx_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances cover 8N1, 8E1, 8O1 and 7E2.
module tb_uart_tx_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] div = 12'd4;
    logic [3:0]  we_v = 4'b0000;
    logic [7:0]  data = 8'h00;

    logic [3:0]  ready_v;
    logic [3:0]  ovf_v;
    logic [3:0]  busy_v;
    logic [3:0]  tx_v;
    logic [2:0]  cnt_v [4];

    logic        tx_m, busy_m, ready_m, ovf_m;
    logic [2:0]  cnt_m;
    int          sel = 0;
    int          checks = 0;
    int          errors = 0;
    logic        cap [0:1023];

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(12), .FIFO_AW(2)) u0 (
        .clk(clk), .rst(rst), .div(div), .we(we_v[0]), .data(data),
        .ready(ready_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]), .tx(tx_v[0]));
    uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DIV_W(12), .FIFO_AW(2)) u1 (
        .clk(clk), .rst(rst), .div(div), .we(we_v[1]), .data(data),
        .ready(ready_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]), .tx(tx_v[1]));
    uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(12), .FIFO_AW(2)) u2 (
        .clk(clk), .rst(rst), .div(div), .we(we_v[2]), .data(data),
        .ready(ready_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2]), .tx(tx_v[2]));
    uart_tx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DIV_W(12), .FIFO_AW(2)) u3 (
        .clk(clk), .rst(rst), .div(div), .we(we_v[3]), .data(data[6:0]),
        .ready(ready_v[3]), .ovf(ovf_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3]), .tx(tx_v[3]));

    always_comb begin
        tx_m    = tx_v[sel];
        busy_m  = busy_v[sel];
        ready_m = ready_v[sel];
        ovf_m   = ovf_v[sel];
        cnt_m   = cnt_v[sel];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            cap[start + i] = tx_m;
        end
    endtask

    task automatic test_reset();
        sel = 0;
        rst = 1'b1;
        step();
        step();
        checks++; if (tx_m !== 1'b1)      begin errors++; $display("FAIL reset_tx got %0b exp 1", tx_m); end
        checks++; if (ready_m !== 1'b1)   begin errors++; $display("FAIL reset_ready got %0b exp 1", ready_m); end
        checks++; if (ovf_m !== 1'b0)     begin errors++; $display("FAIL reset_ovf got %0b exp 0", ovf_m); end
        checks++; if (busy_m !== 1'b0)    begin errors++; $display("FAIL reset_busy got %0b exp 0", busy_m); end
        checks++; if (cnt_m !== 3'd0)     begin errors++; $display("FAIL reset_count got %0d exp 0", cnt_m); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [9:0] fr;
        int bad;
        bad = 0;
        sel = 0; div = 12'd4; fr = 10'h2AA;
        data = 8'h55; we_v[0] = 1'b1;
        step();
        we_v[0] = 1'b0;
        checks++; if (tx_m !== 1'b1)  begin errors++; $display("FAIL basic_tx_before_start got %0b exp 1", tx_m); end
        checks++; if (cnt_m !== 3'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", cnt_m); end
        capture(0, 40);
        for (int c = 0; c < 40; c++) if (cap[c] !== fr[c/4]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_frame got %0d bad cycles exp 0", bad); end
        checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL basic_busy_in_stop got %0b exp 1", busy_m); end
        step();
        checks++; if (busy_m !== 1'b0 || tx_m !== 1'b1) begin
            errors++; $display("FAIL basic_idle got busy=%0b tx=%0b exp busy=0 tx=1", busy_m, tx_m); end
    endtask

    task automatic test_parity();
        logic [10:0] fr [4];
        logic [7:0]  dv [4];
        int bad;
        fr[1] = 11'h60E; fr[2] = 11'h40E; fr[3] = 11'h7FE;
        dv[1] = 8'h07;   dv[2] = 8'h07;   dv[3] = 8'h7F;
        div = 12'd3;
        for (int s = 1; s < 4; s++) begin
            sel = s; bad = 0;
            data = dv[s]; we_v[s] = 1'b1;
            step();
            we_v[s] = 1'b0;
            capture(0, 33);
            for (int c = 0; c < 33; c++) if (cap[c] !== fr[s][c/3]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL parity_frame_u%0d got %0d bad cycles exp 0", s, bad); end
            step();
            checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL parity_idle_u%0d got busy=%0b exp 0", s, busy_m); end
        end
        sel = 0;
    endtask

    task automatic test_fifo_ovf();
        logic [7:0] fd [6];
        logic [2:0] cnt_e [6];
        logic       rdy_e [6];
        logic       ovf_e [6];
        logic [9:0] fr;
        int bad;
        fd    = '{8'h3C, 8'hA5, 8'h0F, 8'hF0, 8'h81, 8'h7E};
        cnt_e = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        rdy_e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        ovf_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        sel = 0; div = 12'd10; bad = 0;
        for (int i = 0; i < 6; i++) begin
            data = fd[i]; we_v[0] = 1'b1;
            step();
            if (i >= 1) cap[i-1] = tx_m;
            checks++; if (cnt_m !== cnt_e[i])   begin errors++; $display("FAIL ovf_count_%0d got %0d exp %0d", i, cnt_m, cnt_e[i]); end
            checks++; if (ready_m !== rdy_e[i]) begin errors++; $display("FAIL ovf_ready_%0d got %0b exp %0b", i, ready_m, rdy_e[i]); end
            checks++; if (ovf_m !== ovf_e[i])   begin errors++; $display("FAIL ovf_pulse_%0d got %0b exp %0b", i, ovf_m, ovf_e[i]); end
        end
        we_v[0] = 1'b0;
        step();
        cap[5] = tx_m;
        checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", ovf_m); end
        capture(6, 494);
        for (int c = 0; c < 500; c++) begin
            fr = {1'b1, fd[c/100], 1'b0};
            if (cap[c] !== fr[(c%100)/10]) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ovf_frames got %0d bad cycles exp 0", bad); end
        step();
        checks++; if (busy_m !== 1'b0 || cnt_m !== 3'd0) begin
            errors++; $display("FAIL ovf_drain got busy=%0b count=%0d exp 0 0", busy_m, cnt_m); end
    endtask

    task automatic test_div();
        logic [9:0] fa, fb;
        int bad;
        sel = 0; bad = 0;
        div = 12'd1; fa = 10'h21E;
        data = 8'h0F; we_v[0] = 1'b1;
        step();
        we_v[0] = 1'b0;
        capture(0, 20);
        for (int c = 0; c < 20; c++) if (cap[c] !== fa[c/2]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL div_clamp got %0d bad cycles exp 0", bad); end
        step();
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL div_clamp_idle got %0b exp 0", busy_m); end

        div = 12'd4; fa = 10'h386; fb = 10'h2B4; bad = 0;
        data = 8'hC3; we_v[0] = 1'b1;
        step();
        data = 8'h5A;
        step();
        cap[0] = tx_m;
        we_v[0] = 1'b0;
        for (int n = 2; n <= 120; n++) begin
            if (n == 6) div = 12'd8;
            step();
            cap[n-1] = tx_m;
        end
        for (int c = 0; c < 120; c++) begin
            if (c < 40) begin
                if (cap[c] !== fa[c/4]) bad++;
            end else begin
                if (cap[c] !== fb[(c-40)/8]) bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL div_change got %0d bad cycles exp 0", bad); end
        step();
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL div_change_idle got %0b exp 0", busy_m); end
        div = 12'd4;
    endtask

    task automatic test_reset_mid();
        int bad;
        sel = 0; div = 12'd4; bad = 0;
        data = 8'h00; we_v[0] = 1'b1; step();
        data = 8'h11; step();
        data = 8'h22; step();
        we_v[0] = 1'b0;
        for (int i = 0; i < 16; i++) step();
        checks++; if (tx_m !== 1'b0 || cnt_m !== 3'd2) begin
            errors++; $display("FAIL rstmid_pre got tx=%0b count=%0d exp tx=0 count=2", tx_m, cnt_m); end
        rst = 1'b1;
        step();
        checks++; if (tx_m !== 1'b1)    begin errors++; $display("FAIL rstmid_tx got %0b exp 1", tx_m); end
        checks++; if (cnt_m !== 3'd0)   begin errors++; $display("FAIL rstmid_count got %0d exp 0", cnt_m); end
        checks++; if (busy_m !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got %0b exp 0", busy_m); end
        rst = 1'b0;
        capture(0, 60);
        for (int c = 0; c < 60; c++) if (cap[c] !== 1'b1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_silent got %0d low cycles exp 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fd [3];
        logic [9:0] fr;
        int bad;
        fd = '{8'h12, 8'h34, 8'h56};
        sel = 0; div = 12'd4; bad = 0;
        data = fd[0]; we_v[0] = 1'b1;
        step();
        we_v[0] = 1'b0;
        for (int n = 1; n <= 120; n++) begin
            if (n == 2)  begin data = fd[1]; we_v[0] = 1'b1; end
            if (n == 41) begin data = fd[2]; we_v[0] = 1'b1; end
            step();
            we_v[0] = 1'b0;
            cap[n-1] = tx_m;
            if (n == 41) begin
                checks++; if (cnt_m !== 3'd1) begin errors++; $display("FAIL b2b_count got %0d exp 1", cnt_m); end
            end
        end
        for (int c = 0; c < 120; c++) begin
            fr = {1'b1, fd[c/40], 1'b0};
            if (cap[c] !== fr[(c%40)/4]) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_frames got %0d bad cycles exp 0", bad); end
        step();
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b exp 0", busy_m); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_fifo_ovf();
        test_div();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
